// File: rtl/result_uart_tx.sv
// result_uart_tx: queues each new mux result and sends it as an ASCII digit on an 8N1 serial line
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    result,
  input  logic                          enable,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [2:0]    prev;
  logic          prev_valid;
  logic [7:0]    sh;
  logic [2:0]    bitn;
  logic [CW-1:0] cyc;
  logic          push, full, wr, pop, last;
  always_comb begin
    push = enable && (!prev_valid || result != prev);
    full = fifo_count == NW'(FIFO_DEPTH);
    wr   = push && !full;
    pop  = state == IDLE && fifo_count != '0;
    last = cyc == CW'(CLKS_PER_BIT - 1);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= result;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      sh         <= '0;
      bitn       <= '0;
      cyc        <= '0;
    end else begin
      if (enable) begin
        prev       <= result;
        prev_valid <= 1'b1;
      end
      if (push && full) overflow <= 1'b1;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + NW'(wr) - NW'(pop);
      cyc <= (state == IDLE || last) ? '0 : cyc + 1'b1;
      // tx is registered, so each state's line level is set on the edge that enters it
      case (state)
        IDLE: if (pop) begin
          state <= START;
          tx    <= 1'b0;
          sh    <= 8'h30 | {5'b0, mem[rp]};
        end
        START: if (last) begin
          state <= DATA;
          bitn  <= '0;
          tx    <= sh[0];
        end
        DATA: if (last) begin
          sh <= sh >> 1;
          if (bitn == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            bitn <= bitn + 3'd1;
            tx   <= sh[1];
          end
        end
        STOP: if (last) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed checks of framing, latency, FIFO overflow, enable gating and reset
module tb_result_uart_tx;
  logic       clk = 0, rst = 1, enable = 0, tx, busy, overflow;
  logic [2:0] result = 0;
  logic [2:0] fifo_count;
  int         checks = 0, errors = 0;
  int         dly, n;
  logic [7:0] b;

  result_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .result(result), .enable(enable),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int lows = 0;
    repeat (cycles) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  // waits (bounded) for a start bit, captures 40 cycles, returns the byte; ends on the cycle after the stop bit
  task automatic recv(input string tag, input int limit, output int d, output logic [7:0] v);
    logic [39:0] w;
    int bad = 0;
    d = 0;
    while (tx !== 1'b0 && d < limit) begin
      tick();
      d++;
    end
    chk({tag, "_start"}, tx, 0);
    for (int i = 0; i < 40; i++) begin
      w[i] = tx;
      if (busy !== 1'b1) bad++;
      tick();
    end
    for (int k = 0; k < 10; k++)
      if (w[4*k +: 4] != {4{w[4*k]}}) bad++;
    if (w[0] !== 1'b0 || w[36] !== 1'b1) bad++;
    for (int k = 0; k < 8; k++) v[k] = w[4*(k+1)];
    chk({tag, "_framing"}, bad, 0);
    chk({tag, "_idle_busy"}, {tx, busy}, 2'b10);
  endtask

  initial begin
    // 1. reset
    tick();
    tick();
    chk("rst_outputs", {tx, busy, fifo_count, overflow}, {1'b1, 1'b0, 3'd0, 1'b0});
    rst = 0;
    quiet("rst_idle100", 100);

    // 2. single value 5
    result = 5;
    enable = 1;
    tick();
    chk("s2_queued", {tx, fifo_count}, {1'b1, 3'd1});
    tick();
    chk("s2_popped", {tx, busy, fifo_count}, {1'b0, 1'b1, 3'd0});
    recv("s2", 0, dly, b);
    chk("s2_byte", b, 8'h35);
    quiet("s2_no_more", 60);

    // 3. change 5 -> 2
    result = 2;
    recv("s3", 10, dly, b);
    chk("s3_latency", dly, 2);
    chk("s3_byte", b, 8'h32);

    // 4. overflow during an in-flight frame of '0'
    result = 0;
    tick();
    tick();
    chk("s4_start", {tx, busy}, 2'b01);
    result = 1; tick();
    result = 2; tick();
    result = 3; tick();
    result = 4; tick();
    chk("s4_full_no_ovf", {fifo_count, overflow}, {3'd4, 1'b0});
    result = 6; tick();
    chk("s4_ovf", {fifo_count, overflow}, {3'd4, 1'b1});
    repeat (35) tick();
    chk("s4_gap", {tx, busy}, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      recv("s4", 5, dly, b);
      chk("s4_gap_len", dly, 1);
      chk("s4_byte", b, 8'h30 + i);
    end
    chk("s4_after", {fifo_count, overflow}, {3'd0, 1'b1});
    quiet("s4_dropped6", 60);
    chk("s4_ovf_sticky", overflow, 1);

    // 5. enable gating
    enable = 0;
    result = 3; tick();
    result = 7; tick();
    result = 1; tick();
    quiet("s5_disabled", 50);
    enable = 1;
    result = 6;
    quiet("s5_same_value", 50);
    result = 5;
    recv("s5", 10, dly, b);
    chk("s5_latency", dly, 2);
    chk("s5_byte", b, 8'h35);

    // 6. reset during DATA bit 3 with two values queued
    result = 1;
    tick();
    tick();
    n = 0;
    result = 2; tick();
    result = 3; tick();
    chk("s6_queued", fifo_count, 2);
    repeat (15) tick();
    chk("s6_mid_bit3", {busy, tx}, 2'b10);
    rst = 1;
    tick();
    chk("s6_rst", {tx, busy, fifo_count, overflow}, {1'b1, 1'b0, 3'd0, 1'b0});
    rst = 0;
    recv("s6", 10, dly, b);
    chk("s6_latency", dly, 2);
    chk("s6_byte", b, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
